// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the extended UART receiver.
//   parity_t   - parity mode selection (none / odd / even)
//   rx_state_t - receiver FSM states
//   maj3       - 3-input majority vote used for bit sampling
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// uart_rx_ext_if: ready/valid output stream of the UART receiver.
//   o_rx_valid      - head entry valid (receiver -> consumer)
//   i_rx_ready      - consumer accepts head (consumer -> receiver)
//   o_rx_data       - head data word
//   o_rx_parity_err - head flag: parity mismatch
//   o_rx_frame_err  - head flag: a stop bit was sampled low
// master = receiver side, slave = consumer side.
interface uart_rx_ext_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 o_rx_valid;
  logic                 i_rx_ready;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_parity_err;
  logic                 o_rx_frame_err;

  modport master (
    output o_rx_valid,
    output o_rx_data,
    output o_rx_parity_err,
    output o_rx_frame_err,
    input  i_rx_ready
  );

  modport slave (
    input  o_rx_valid,
    input  o_rx_data,
    input  o_rx_parity_err,
    input  o_rx_frame_err,
    output i_rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: single-clock show-ahead FIFO with asynchronous active-high reset.
//   clk, rst  - clock, async reset (empties the FIFO)
//   push_i    - write wdata_i; accepted when not full, or when full and popping
//   wdata_i   - write data
//   pop_i     - remove head; ignored when empty
//   rdata_o   - head entry, reads 0 when empty
//   full_o    - FIFO full
//   empty_o   - FIFO empty
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // When full, a simultaneous pop frees the head slot that the push then reuses.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver with majority-vote sampling, parity/framing
// error tagging, break detection and a ready/valid output FIFO.
//   clk, rst   - clock, asynchronous active-high reset
//   i_rx_data  - raw serial line (idle high, asynchronous)
//   rx_if      - output stream (valid/ready, data, parity_err, frame_err)
//   o_rx_busy  - high whenever the FSM is not idle
//   o_overrun  - one-cycle pulse: completed word dropped, FIFO full
//   o_break    - one-cycle pulse: break condition detected
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter parity_t     PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rx_data,
  uart_rx_ext_if.master rx_if,
  output logic          o_rx_busy,
  output logic          o_overrun,
  output logic          o_break
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned FW = DATA_BITS + 2;

  localparam logic [CW-1:0] HalfM1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] Half    = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] HalfP1  = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DataLast = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);

  rx_state_t            state_q;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q;      // cycle offset within the current bit
  logic [BW-1:0]        bit_cnt_q;  // data-bit or stop-bit index
  logic                 s0_q, s1_q; // samples at center-1 and center
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q, par_err_q;
  logic                 stop0_q, stop_bad_q;
  logic                 push_q, break_q;
  logic [FW-1:0]        word_q;

  logic line, vote, sample_now, par_err_now, first_stop, stop_bad_now, is_break;

  assign line       = sync_q[1];
  // The third vote is the live line at center+1, so the decision lands on that cycle.
  assign vote       = maj3(s0_q, s1_q, line);
  assign sample_now = (cnt_q == HalfP1);

  assign par_err_now  = (PARITY == PAR_ODD) ? ~(^shift_q ^ vote) : (^shift_q ^ vote);
  assign first_stop   = (bit_cnt_q == '0) ? vote : stop0_q;
  assign stop_bad_now = stop_bad_q | ~vote;
  assign is_break     = (shift_q == '0) && !par_bit_q && !first_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stop0_q    <= 1'b1;
      stop_bad_q <= 1'b0;
      push_q     <= 1'b0;
      break_q    <= 1'b0;
      word_q     <= '0;
    end else begin
      sync_q  <= {sync_q[0], i_rx_data};
      push_q  <= 1'b0;
      break_q <= 1'b0;

      if (state_q inside {StStart, StData, StParity, StStop}) begin
        cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        if (cnt_q == HalfM1) s0_q <= line;
        if (cnt_q == Half)   s1_q <= line;
      end

      case (state_q)
        StIdle: begin
          if (!line) begin
            state_q    <= StStart;
            // The detecting cycle is offset 0 of the start bit.
            cnt_q      <= CW'(1);
            bit_cnt_q  <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            stop_bad_q <= 1'b0;
          end
        end
        StStart: begin
          if (sample_now) state_q <= vote ? StIdle : StData;
        end
        StData: begin
          if (sample_now) begin
            shift_q <= {vote, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DataLast) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY == PAR_NONE) ? StStop : StParity;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (sample_now) begin
            par_bit_q <= vote;
            par_err_q <= par_err_now;
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (sample_now) begin
            if (bit_cnt_q == '0) stop0_q <= vote;
            if (bit_cnt_q == StopLast) begin
              bit_cnt_q <= '0;
              if (is_break) begin
                break_q <= 1'b1;
                state_q <= StWaitIdle;
              end else begin
                push_q  <= 1'b1;
                word_q  <= {shift_q, par_err_q, stop_bad_now};
                // Leaving half a bit early lets a back-to-back start bit be caught.
                state_q <= stop_bad_now ? StWaitIdle : StIdle;
              end
            end else begin
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              stop_bad_q <= stop_bad_now;
            end
          end
        end
        StWaitIdle: begin
          if (line) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic          fifo_full, fifo_empty, pop;
  logic [FW-1:0] fifo_rdata;

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .wdata_i (word_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop              = ~fifo_empty & rx_if.i_rx_ready;
  assign rx_if.o_rx_valid = ~fifo_empty;
  assign {rx_if.o_rx_data, rx_if.o_rx_parity_err, rx_if.o_rx_frame_err} = fifo_rdata;

  assign o_rx_busy = (state_q != StIdle);
  assign o_break   = break_q;
  assign o_overrun = push_q & fifo_full & ~pop;

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: self-checking bench for uart_rx_ext (16 clk/bit, 8E1, 4-deep FIFO).
// Expected words come from the frame fields sent (parity rule, stop bit, break rule).
module tb_uart_rx_ext;
  import uart_pkg::*;

  localparam int Period = 10;
  localparam int Bt     = 16 * Period;  // nominal bit time

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic busy, ovr, brk;

  uart_rx_ext_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_ext #(
    .CLKS_PER_BIT (16),
    .DATA_BITS    (8),
    .PARITY       (PAR_EVEN),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_rx_data (rx),
    .rx_if     (rx_if),
    .o_rx_busy (busy),
    .o_overrun (ovr),
    .o_break   (brk)
  );

  always #(Period / 2) clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Observation only: popped words and pulse/busy counts, sampled on the falling edge.
  logic [9:0] got_q[$];
  int ov_cnt   = 0;
  int br_cnt   = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.o_rx_valid && rx_if.i_rx_ready)
        got_q.push_back({rx_if.o_rx_data, rx_if.o_rx_parity_err, rx_if.o_rx_frame_err});
      if (ovr)  ov_cnt <= ov_cnt + 1;
      if (brk)  br_cnt <= br_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  logic [9:0] exp_q[$];
  int got_rd = 0;
  int exp_br = 0;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                            input int bt);
    rx = 1'b0;
    #bt;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #bt;
    end
    rx = pbit;
    #bt;
    rx = stopb;
    #bt;
    rx = 1'b1;
  endtask

  // Reference model: what one frame should produce, from the frame fields alone.
  task automatic model_frame(input logic [7:0] d, input logic pbit, input logic stopb);
    if (d == 8'h00 && !pbit && !stopb) exp_br++;
    else exp_q.push_back({d, (^d) ^ pbit, ~stopb});
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (rx_if.o_rx_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid got %b want 0", rx_if.o_rx_valid); end
    n_tests++; if (rx_if.o_rx_data !== 8'h00) begin n_fail++;
      $display("FAIL reset_data got %h want 00", rx_if.o_rx_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b want 0", busy); end
    cycles(3);
    rst = 1'b0;
    cycles(5);
    n_tests++; if ({rx_if.o_rx_valid, rx_if.o_rx_parity_err, rx_if.o_rx_frame_err, ovr, brk, busy}
                   !== 6'b0) begin n_fail++;
      $display("FAIL idle_outputs got %b want 000000",
               {rx_if.o_rx_valid, rx_if.o_rx_parity_err, rx_if.o_rx_frame_err, ovr, brk, busy});
    end
  endtask

  task automatic test_clean();
    int ov0 = ov_cnt;
    int br0 = br_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, Bt);
    model_frame(8'hA5, 1'b0, 1'b1);
    cycles(48);
    n_tests++; if (got_q.size() - got_rd !== exp_q.size()) begin n_fail++;
      $display("FAIL clean_count got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      logic [9:0] e = exp_q.pop_front();
      n_tests++; if (got_q[got_rd] !== e) begin n_fail++;
        $display("FAIL clean_word got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    exp_q.delete();
    n_tests++; if (ov_cnt - ov0 !== 0 || br_cnt - br0 !== 0) begin n_fail++;
      $display("FAIL clean_pulses got ov=%0d br=%0d want 0 0", ov_cnt - ov0, br_cnt - br0); end
  endtask

  task automatic test_errors();
    send_frame(8'h3C, 1'b1, 1'b1, Bt);
    model_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, Bt);
    model_frame(8'h3C, 1'b0, 1'b0);
    #Bt;
    send_frame(8'h55, 1'b0, 1'b1, Bt);
    model_frame(8'h55, 1'b0, 1'b1);
    cycles(48);
    n_tests++; if (got_q.size() - got_rd !== exp_q.size()) begin n_fail++;
      $display("FAIL err_count got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      logic [9:0] e = exp_q.pop_front();
      n_tests++; if (got_q[got_rd] !== e) begin n_fail++;
        $display("FAIL err_word got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    exp_q.delete();
  endtask

  task automatic test_glitch();
    int b0 = busy_cnt;
    int g0 = got_q.size();
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(40);
    n_tests++; if (busy_cnt - b0 < 1 || busy_cnt - b0 > 12) begin n_fail++;
      $display("FAIL glitch_busy got %0d busy cycles want 1..12", busy_cnt - b0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL glitch_idle got busy=%b want 0", busy); end
    n_tests++; if (got_q.size() !== g0 || rx_if.o_rx_valid !== 1'b0) begin n_fail++;
      $display("FAIL glitch_push got %0d words want 0", got_q.size() - g0); end
  endtask

  task automatic test_overrun();
    logic [9:0] mq[$];
    int exp_ov = 0;
    int ov0 = ov_cnt;
    int ov4;
    rx_if.i_rx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] d = 8'(k);
      send_frame(d, ^d, 1'b1, Bt);
      if (mq.size() < 4) mq.push_back({d, 2'b00});
      else exp_ov++;
      if (k == 4) ov4 = ov_cnt;
    end
    cycles(48);
    n_tests++; if (ov4 - ov0 !== 0) begin n_fail++;
      $display("FAIL overrun_early got %0d want 0", ov4 - ov0); end
    n_tests++; if (ov_cnt - ov0 !== exp_ov) begin n_fail++;
      $display("FAIL overrun_count got %0d want %0d", ov_cnt - ov0, exp_ov); end
    rx_if.i_rx_ready = 1'b1;
    cycles(10);
    n_tests++; if (got_q.size() - got_rd !== mq.size()) begin n_fail++;
      $display("FAIL overrun_drain got %0d want %0d", got_q.size() - got_rd, mq.size()); end
    while (mq.size() > 0 && got_rd < got_q.size()) begin
      logic [9:0] e = mq.pop_front();
      n_tests++; if (got_q[got_rd] !== e) begin n_fail++;
        $display("FAIL overrun_word got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    n_tests++; if (rx_if.o_rx_valid !== 1'b0) begin n_fail++;
      $display("FAIL overrun_empty got valid=%b want 0", rx_if.o_rx_valid); end
  endtask

  task automatic test_break();
    int br0 = br_cnt;
    int g0  = got_q.size();
    rx = 1'b0;
    #(12 * Bt);
    n_tests++; if (busy !== 1'b1) begin n_fail++;
      $display("FAIL break_busy got %b want 1", busy); end
    rx = 1'b1;
    cycles(6);
    n_tests++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL break_release got busy=%b want 0", busy); end
    n_tests++; if (br_cnt - br0 !== 1 || got_q.size() !== g0) begin n_fail++;
      $display("FAIL break_pulse got br=%0d words=%0d want 1 0", br_cnt - br0, got_q.size() - g0);
    end
    send_frame(8'h55, 1'b0, 1'b1, Bt);
    cycles(48);
    n_tests++; if (got_q.size() !== g0 + 1) begin n_fail++;
      $display("FAIL break_next_count got %0d want 1", got_q.size() - g0); end
    else if (got_q[g0] !== {8'h55, 2'b00}) begin n_fail++;
      $display("FAIL break_next_word got %h want %h", got_q[g0], {8'h55, 2'b00}); end
    got_rd = got_q.size();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d     = 8'($urandom);
      logic       pbit;
      logic       stopb = ($urandom_range(5) != 0);
      int         bt;
      case ($urandom_range(2))
        0: bt = Bt - 5;
        1: bt = Bt;
        default: bt = Bt + 5;
      endcase
      if ($urandom_range(7) == 0) d = 8'h00;
      pbit = (^d) ^ ($urandom_range(4) == 0);
      send_frame(d, pbit, stopb, bt);
      model_frame(d, pbit, stopb);
      if (!stopb || bt != Bt) #Bt;
    end
    cycles(48);
    n_tests++; if (got_q.size() - got_rd !== exp_q.size()) begin n_fail++;
      $display("FAIL rand_count got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      logic [9:0] e = exp_q.pop_front();
      n_tests++; if (got_q[got_rd] !== e) begin n_fail++;
        $display("FAIL rand_word got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int br0 = br_cnt;
    rx_if.i_rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, Bt);
    cycles(48);
    n_tests++; if (rx_if.o_rx_valid !== 1'b1) begin n_fail++;
      $display("FAIL mid_queued got valid=%b want 1", rx_if.o_rx_valid); end
    rx = 1'b0;
    #(4 * Bt);
    n_tests++; if (busy !== 1'b1) begin n_fail++;
      $display("FAIL mid_busy got %b want 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if ({rx_if.o_rx_valid, rx_if.o_rx_data, rx_if.o_rx_parity_err,
                    rx_if.o_rx_frame_err, busy, ovr, brk} !== 14'b0) begin n_fail++;
      $display("FAIL mid_async got %b want all zero", {rx_if.o_rx_valid, rx_if.o_rx_data,
               rx_if.o_rx_parity_err, rx_if.o_rx_frame_err, busy, ovr, brk});
    end
    rx = 1'b1;
    cycles(3);
    rst = 1'b0;
    rx_if.i_rx_ready = 1'b1;
    cycles(5);
    got_rd = got_q.size();
    send_frame(8'h81, 1'b0, 1'b1, Bt);
    cycles(48);
    n_tests++; if (got_q.size() - got_rd !== 1) begin n_fail++;
      $display("FAIL mid_after_count got %0d want 1", got_q.size() - got_rd); end
    else if (got_q[got_rd] !== {8'h81, 2'b00}) begin n_fail++;
      $display("FAIL mid_after_word got %h want %h", got_q[got_rd], {8'h81, 2'b00}); end
    n_tests++; if (br_cnt - br0 !== 0) begin n_fail++;
      $display("FAIL mid_break got %0d want 0", br_cnt - br0); end
  endtask

  initial begin
    rx_if.i_rx_ready = 1'b1;
    test_reset();
    test_clean();
    test_errors();
    test_glitch();
    test_overrun();
    test_break();
    exp_br = br_cnt;
    test_random();
    n_tests++; if (br_cnt !== exp_br) begin n_fail++;
      $display("FAIL rand_break got %0d want %0d", br_cnt, exp_br); end
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver, successor to the fixed 8n1 receiver. Adds:
- configurable data width, parity and stop bits
- 3-sample majority voting with start-bit glitch rejection
- framing/parity error tagging, break detection
- small ready/valid output FIFO with overrun reporting

Sits between the board RX pin and byte-consuming logic, e.g. the command parser.

## Interface
- CLKS_PER_BIT, 16: clocks per bit period; minimum 4.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, PAR_NONE: one of PAR_NONE, PAR_ODD, PAR_EVEN.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: output FIFO entries, power of 2, at least 2.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_rx_data  in  1  raw serial line, idle high, asynchronous to clk.
- o_rx_valid  out  1  FIFO head valid.
- i_rx_ready  in  1  consumer accepts the head when high together with o_rx_valid.
- o_rx_data  out  DATA_BITS  FIFO head data.
- o_rx_parity_err  out  1  FIFO head flag: parity mismatch; always 0 when PARITY = PAR_NONE.
- o_rx_frame_err  out  1  FIFO head flag: a stop bit was sampled low.
- o_rx_busy  out  1  high in every state except IDLE.
- o_overrun  out  1  one-cycle pulse: a completed word was dropped because the FIFO was full.
- o_break  out  1  one-cycle pulse: break detected.

## Operation
- **Input sync:** 2-flop synchroniser on i_rx_data, reset to 1. "Line" below means the synchronised value.
- **Bit sampling:** each bit is the majority of the line at cycles center-1, center, center+1.
  - center = CLKS_PER_BIT/2 cycles after the bit's first cycle (integer division).
- **States:**
  - IDLE → START on line = 0.
  - START: at start-bit center, majority = 1 → IDLE (glitch, no push); majority = 0 → DATA.
  - DATA: samples DATA_BITS bits at one-bit spacing → PARITY if PARITY ≠ PAR_NONE, else STOP.
  - PARITY: samples one bit → STOP.
  - STOP: samples STOP_BITS bits. After the last stop sample:
    - all stops 1 → IDLE;
    - any stop 0 → WAIT_IDLE.
  - WAIT_IDLE → IDLE on line = 1.
- **Parity check:**
  - even parity: XOR of data bits and parity bit must be 0;
  - odd parity: that XOR must be 1;
  - mismatch sets parity_err.
- **Break:** all data bits 0, parity bit 0 if present, and first stop bit 0.
  - Result: o_break pulse, no FIFO push, go to WAIT_IDLE.
  - Otherwise, any stop sample 0 pushes the word with frame_err = 1.
- **Push:** each completed non-break frame pushes {data, parity_err, frame_err}.
- **FIFO, full with no pop:** the push is dropped and o_overrun pulses.
- **FIFO, simultaneous push and pop when full:** both succeed, no overrun.
- **FIFO, pop when empty:** ignored.
- **Order:** strict FIFO; no reordering.
- **FIFO outputs:** when the FIFO is empty, o_rx_data and both error flags read 0.
- **Reset (async, any time including mid-frame):**
  - state = IDLE, FIFO emptied, sync flops = 1;
  - every output is 0 immediately, without waiting for a clock edge.

## Timing
- **Start detect:** 2 cycles from the i_rx_data falling edge to line = 0.
- **Start-bit center:** START sample taken CLKS_PER_BIT/2 cycles after the first line = 0 cycle.
- **Later samples:** every subsequent center is CLKS_PER_BIT cycles after the previous one.
- **Push:** occurs on the cycle after the last stop-bit center+1 sample.
- **Valid:** o_rx_valid rises on the cycle after the push when the FIFO was empty.
- **Return to IDLE:** IDLE is entered about half a bit before the nominal frame end, so back-to-back frames with no idle gap are received without loss.
- **o_rx_busy:** rises the cycle after start detect and falls when IDLE is re-entered.
- **Pulses:** o_overrun and o_break are exactly one cycle, on the cycle the push would have occurred.
- **Handshake:** a pop happens at the clock edge where o_rx_valid and i_rx_ready are both high. The next entry, if present, is visible the following cycle.
- **Tolerance:** correct reception with ±3% baud mismatch at CLKS_PER_BIT = 16.

## Structure
- **Package uart_pkg:**
  - parity_t enum (PAR_NONE, PAR_ODD, PAR_EVEN);
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE).
- **Sub-module uart_rx_fifo:**
  - synchronous single-clock FIFO, same async reset;
  - width DATA_BITS+2, depth FIFO_DEPTH;
  - outputs full/empty, show-ahead head.
- **Counters:** clock counter width $clog2(CLKS_PER_BIT+1); bit counter width $clog2(DATA_BITS+1).

## Test plan
Bench config: CLKS_PER_BIT = 16, DATA_BITS = 8, PARITY = PAR_EVEN, STOP_BITS = 1, FIFO_DEPTH = 4, i_rx_ready = 1 unless stated.

- Frame 0xA5, parity bit 0 → o_rx_valid with o_rx_data = 0xA5, both error flags 0, no o_break or o_overrun.
- Frame 0x3C with parity bit 1 → o_rx_data = 0x3C, o_rx_parity_err = 1. Then a frame 0x3C with stop bit 0 → o_rx_frame_err = 1, and the next frame 0x55 is received clean.
- Low glitch on i_rx_data of 3 cycles → o_rx_busy pulses high, returns to IDLE, no push.
- i_rx_ready = 0, five frames 0x01..0x05 → one o_overrun pulse during frame 5. Then i_rx_ready = 1 → pops 0x01, 0x02, 0x03, 0x04, then o_rx_valid = 0.
- Line held low for 12 bit times, then high → one o_break pulse, no push, o_rx_busy high until the line is high. Following frame 0x55 → o_rx_data = 0x55.
- Assert rst mid-DATA with one word queued → all outputs 0 without waiting for a clock edge. Release, send 0x81 → o_rx_data = 0x81, flags 0.
